// File: rtl/discrete_sfx_pkg.sv
// Shared types and width helpers for the discrete sound effect sequencer.
package discrete_sfx_pkg;

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE, RELEASE} sfx_state_t;

  localparam int unsigned ACC_W = 32;

  // Hold and tail share one down-counter per channel, sized for the larger of the two.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tail);
    int unsigned span;
    span = (hold > tail) ? hold : tail;
    return (span == 0) ? 1 : int'($clog2(span + 1));
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Fractional accumulator producing a one-clk audio sample tick at exactly SAMPLE_RATE/CLOCK_RATE.
module sample_tick_gen
  import discrete_sfx_pkg::*;
#(
  parameter int unsigned CLOCK_RATE  = 1000000,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic clk,
  input  logic I_RSTn,
  output logic tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;

  always_comb nxt = acc + ACC_W'(SAMPLE_RATE);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (nxt >= ACC_W'(CLOCK_RATE)) begin
      acc  <= nxt - ACC_W'(CLOCK_RATE);
      tick <= 1'b1;
    end else begin
      acc  <= nxt;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/discrete_sfx_sequencer.sv
// Sequencer for the discrete sound circuits: sample tick, latch request sync, per-channel
// play/tail FSMs and fixed-priority slot arbitration. Build option SFX_PREEMPT_EN lets a
// blocked request evict the highest-index occupied lower-priority channel.
module discrete_sfx_sequencer
  import discrete_sfx_pkg::*;
#(
  parameter int unsigned CLOCK_RATE       = 1000000,
  parameter int unsigned SAMPLE_RATE      = 48000,
  parameter int unsigned NUM_SFX          = 4,
  parameter int unsigned MAX_ACTIVE       = 2,
  parameter int unsigned MIN_HOLD_SAMPLES = 2400,
  parameter int unsigned TAIL_SAMPLES     = 4800
) (
  input  logic                              clk,
  input  logic                              I_RSTn,
  input  logic [NUM_SFX-1:0]                trig_req,
  output logic                              audio_clk_en,
  output logic [NUM_SFX-1:0]                sfx_en,
  output logic [NUM_SFX-1:0]                sfx_pending,
  output logic [$clog2(MAX_ACTIVE+1)-1:0]   active_count
);

  localparam int unsigned CW = cnt_width(MIN_HOLD_SAMPLES, TAIL_SAMPLES);
  localparam int unsigned OW = $clog2(NUM_SFX + 1);
  localparam int unsigned AW = $clog2(MAX_ACTIVE + 1);

  sfx_state_t         state   [NUM_SFX];
  sfx_state_t         state_n [NUM_SFX];
  logic [CW-1:0]      cnt     [NUM_SFX];
  logic [CW-1:0]      cnt_n   [NUM_SFX];

  logic [NUM_SFX-1:0] sync1, sync, sync_d, rise;
  logic [NUM_SFX-1:0] occ_v, req, grant, evict;
  logic [NUM_SFX-1:0] en_n, pend_n;
  logic [OW-1:0]      occ, free, granted, occ_n;
`ifdef SFX_PREEMPT_EN
  logic               seek;
  logic [NUM_SFX-1:0] victim_oh;
`endif

  sample_tick_gen #(
    .CLOCK_RATE  (CLOCK_RATE),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_tick (
    .clk    (clk),
    .I_RSTn (I_RSTn),
    .tick   (audio_clk_en)
  );

  // Two-flop synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      sync1  <= '0;
      sync   <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= trig_req;
      sync   <= sync1;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int i = 0; i < NUM_SFX; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SFX; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
    end
  end

  // Arbitration from registered occupancy, then per-channel next state.
  always_comb begin
    occ     = '0;
    granted = '0;
    grant   = '0;
    evict   = '0;
    occ_n   = '0;
    en_n    = '0;
    pend_n  = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      occ_v[i] = (state[i] == ACTIVE) || (state[i] == RELEASE);
      req[i]   = ((state[i] == IDLE) && rise[i]) || ((state[i] == PENDING) && sync[i]);
      if (occ_v[i]) occ = occ + OW'(1);
    end
    free = (occ >= OW'(MAX_ACTIVE)) ? '0 : OW'(MAX_ACTIVE) - occ;

    for (int i = 0; i < NUM_SFX; i++) begin
      if (req[i] && (granted < free)) begin
        grant[i] = 1'b1;
        granted  = granted + OW'(1);
      end
    end

`ifdef SFX_PREEMPT_EN
    // Only the highest-priority blocked requester may evict, so at most one eviction per clk.
    seek      = 1'b1;
    victim_oh = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (seek && req[i] && !grant[i]) begin
        seek = 1'b0;
        for (int j = 0; j < NUM_SFX; j++) begin
          if ((j > i) && occ_v[j]) begin
            victim_oh    = '0;
            victim_oh[j] = 1'b1;
          end
        end
        if (victim_oh != '0) begin
          grant[i] = 1'b1;
          evict    = victim_oh;
        end
      end
    end
`endif

    for (int i = 0; i < NUM_SFX; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            if (grant[i]) begin
              state_n[i] = ACTIVE;
              cnt_n[i]   = CW'(MIN_HOLD_SAMPLES);
            end else begin
              state_n[i] = PENDING;
            end
          end
        end
        PENDING: begin
          if (!sync[i]) begin
            state_n[i] = IDLE;
          end else if (grant[i]) begin
            state_n[i] = ACTIVE;
            cnt_n[i]   = CW'(MIN_HOLD_SAMPLES);
          end
        end
        ACTIVE: begin
          if (rise[i]) begin
            cnt_n[i] = CW'(MIN_HOLD_SAMPLES);
          end else if ((cnt[i] == '0) && !sync[i]) begin
            state_n[i] = RELEASE;
            cnt_n[i]   = CW'(TAIL_SAMPLES);
          end else if (audio_clk_en && (cnt[i] != '0)) begin
            cnt_n[i] = cnt[i] - CW'(1);
          end
        end
        RELEASE: begin
          if (rise[i]) begin
            state_n[i] = ACTIVE;
            cnt_n[i]   = CW'(MIN_HOLD_SAMPLES);
          end else if (cnt[i] == '0) begin
            state_n[i] = IDLE;
          end else if (audio_clk_en) begin
            cnt_n[i] = cnt[i] - CW'(1);
          end
        end
        default: begin
          state_n[i] = IDLE;
          cnt_n[i]   = '0;
        end
      endcase
      if (evict[i]) begin
        state_n[i] = IDLE;
        cnt_n[i]   = '0;
      end
      en_n[i]   = (state_n[i] == ACTIVE);
      pend_n[i] = (state_n[i] == PENDING);
      if ((state_n[i] == ACTIVE) || (state_n[i] == RELEASE)) occ_n = occ_n + OW'(1);
    end
  end

  // Outputs registered alongside the state they describe.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      sfx_en       <= '0;
      sfx_pending  <= '0;
      active_count <= '0;
    end else begin
      sfx_en       <= en_n;
      sfx_pending  <= pend_n;
      active_count <= AW'(occ_n);
    end
  end

endmodule

// File: tb/tb_discrete_sfx_sequencer.sv
// Self-checking bench for discrete_sfx_sequencer: directed scenarios plus random request
// traffic, all compared each clk against a spec-level reference model.
module tb_discrete_sfx_sequencer;

  localparam int unsigned CR   = 1000000;
  localparam int unsigned SR   = 48000;
  localparam int unsigned NS   = 4;
  localparam int unsigned MA   = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TAIL = 2;

  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_PLAY = 2;
  localparam int M_TAIL = 3;

  logic          clk = 1'b0;
  logic          I_RSTn;
  logic [NS-1:0] trig_req;
  logic          audio_clk_en;
  logic [NS-1:0] sfx_en;
  logic [NS-1:0] sfx_pending;
  logic [1:0]    active_count;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode [NS];
  int m_cnt  [NS];
  logic [NS-1:0] m_s1, m_s2, m_s2d;
  bit     m_tick;
  longint m_n;

  int first_tick, ticks, back2back, guard;
  bit prev, ever;

  discrete_sfx_sequencer #(
    .CLOCK_RATE       (CR),
    .SAMPLE_RATE      (SR),
    .NUM_SFX          (NS),
    .MAX_ACTIVE       (MA),
    .MIN_HOLD_SAMPLES (HOLD),
    .TAIL_SAMPLES     (TAIL)
  ) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .trig_req     (trig_req),
    .audio_clk_en (audio_clk_en),
    .sfx_en       (sfx_en),
    .sfx_pending  (sfx_pending),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_mode[i] = M_OFF;
      m_cnt[i]  = 0;
    end
    m_s1 = '0; m_s2 = '0; m_s2d = '0;
    m_tick = 1'b0;
    m_n = 0;
  endtask

  function automatic bit holds_slot(input int mode);
    return (mode == M_PLAY) || (mode == M_TAIL);
  endfunction

  // One clk edge of the reference behaviour; tick is derived from the exact ratio, not an accumulator.
  task automatic model_edge();
    logic [NS-1:0] rise, want, win, kick;
    int nm [NS];
    int nc [NS];
    int occ, free, ng;
    bit seek;
    int vic;
    rise = m_s2 & ~m_s2d;
    want = '0; win = '0; kick = '0;
    occ = 0; ng = 0;
    for (int i = 0; i < NS; i++) begin
      if (holds_slot(m_mode[i])) occ++;
      want[i] = ((m_mode[i] == M_OFF) && rise[i]) || ((m_mode[i] == M_WAIT) && m_s2[i]);
    end
    free = int'(MA) - occ;
    for (int i = 0; i < NS; i++)
      if (want[i] && ng < free) begin win[i] = 1'b1; ng++; end
    seek = 1'b1;
    vic  = -1;
`ifdef SFX_PREEMPT_EN
    for (int i = 0; i < NS; i++) begin
      if (seek && want[i] && !win[i]) begin
        seek = 1'b0;
        for (int j = NS - 1; j > i; j--)
          if (vic < 0 && holds_slot(m_mode[j])) vic = j;
        if (vic >= 0) begin win[i] = 1'b1; kick[vic] = 1'b1; end
      end
    end
`endif
    for (int i = 0; i < NS; i++) begin
      nm[i] = m_mode[i];
      nc[i] = m_cnt[i];
      if (m_mode[i] == M_OFF) begin
        if (rise[i]) begin
          if (win[i]) begin nm[i] = M_PLAY; nc[i] = HOLD; end
          else nm[i] = M_WAIT;
        end
      end else if (m_mode[i] == M_WAIT) begin
        if (!m_s2[i]) nm[i] = M_OFF;
        else if (win[i]) begin nm[i] = M_PLAY; nc[i] = HOLD; end
      end else if (m_mode[i] == M_PLAY) begin
        if (rise[i]) nc[i] = HOLD;
        else if (m_cnt[i] == 0 && !m_s2[i]) begin nm[i] = M_TAIL; nc[i] = TAIL; end
        else if (m_tick && m_cnt[i] > 0) nc[i] = m_cnt[i] - 1;
      end else begin
        if (rise[i]) begin nm[i] = M_PLAY; nc[i] = HOLD; end
        else if (m_cnt[i] == 0) nm[i] = M_OFF;
        else if (m_tick) nc[i] = m_cnt[i] - 1;
      end
      if (kick[i]) begin nm[i] = M_OFF; nc[i] = 0; end
    end
    for (int i = 0; i < NS; i++) begin
      m_mode[i] = nm[i];
      m_cnt[i]  = nc[i];
    end
    m_s2d = m_s2;
    m_s2  = m_s1;
    m_s1  = trig_req;
    m_n++;
    m_tick = ((m_n * longint'(SR)) / longint'(CR)) != (((m_n - 1) * longint'(SR)) / longint'(CR));
  endtask

  function automatic logic [NS-1:0] mode_mask(input int mode);
    logic [NS-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i] = (m_mode[i] == mode);
    return r;
  endfunction

  function automatic int slot_count();
    int c;
    c = 0;
    for (int i = 0; i < NS; i++) if (holds_slot(m_mode[i])) c++;
    return c;
  endfunction

  task automatic check_all();
    check("model_tick", 32'(audio_clk_en), 32'(m_tick));
    check("model_sfx_en", 32'(sfx_en), 32'(mode_mask(M_PLAY)));
    check("model_pending", 32'(sfx_pending), 32'(mode_mask(M_WAIT)));
    check("model_active_count", 32'(active_count), 32'(slot_count()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while ((active_count != 0 || sfx_pending != 0) && g < 3000) begin
      step();
      g++;
    end
    check(tag, 32'(g < 3000), 32'd1);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RSTn   = 1'b0;
    trig_req = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", 32'(audio_clk_en), 32'd0);
    check("rst_sfx_en", 32'(sfx_en), 32'd0);
    check("rst_pending", 32'(sfx_pending), 32'd0);
    check("rst_active_count", 32'(active_count), 32'd0);
    I_RSTn = 1'b1;

    // Tick generator: 25000 clk at 48 kHz / 1 MHz is exactly 1200 ticks.
    first_tick = 0; ticks = 0; back2back = 0; prev = 1'b0;
    for (int k = 1; k <= 25000; k++) begin
      step();
      if (audio_clk_en) begin
        ticks++;
        if (first_tick == 0) first_tick = k;
        if (prev) back2back++;
      end
      prev = audio_clk_en;
    end
    check("tick_first_edge", 32'(first_tick), 32'd21);
    check("tick_count", 32'(ticks), 32'd1200);
    check("tick_back_to_back", 32'(back2back), 32'd0);

    // Minimum hold and release tail from a one-clk request.
    trig_req[1] = 1'b1;
    step();
    trig_req[1] = 1'b0;
    step();
    check("hold_lat_edge2", 32'(sfx_en[1]), 32'd0);
    step();
    check("hold_lat_edge3", 32'(sfx_en[1]), 32'd1);
    ticks = 0; guard = 0;
    while (sfx_en[1] && guard < 1000) begin
      ticks += int'(audio_clk_en);
      step();
      guard++;
    end
    check("hold_ticks", 32'(ticks), 32'(HOLD));
    ticks = 0; guard = 0;
    while (active_count == 2'd1 && guard < 1000) begin
      ticks += int'(audio_clk_en);
      step();
      guard++;
    end
    check("tail_ticks", 32'(ticks), 32'(TAIL));
    check("tail_idle_count", 32'(active_count), 32'd0);

    // Simultaneous requests: two slots by priority, channel 2 takes channel 0's slot.
    trig_req = 4'b1111;
    repeat (3) step();
    check("arb_en", 32'(sfx_en), 32'(4'b0011));
    check("arb_pending", 32'(sfx_pending), 32'(4'b1100));
    trig_req = 4'b1110;
    guard = 0;
    while (active_count != 2'd1 && guard < 2000) begin
      step();
      guard++;
    end
    check("arb_slot_freed", 32'(sfx_en), 32'(4'b0010));
    step();
    check("arb_ch2_grant", 32'(sfx_en), 32'(4'b0110));
    check("arb_pending_after", 32'(sfx_pending), 32'(4'b1000));
    trig_req = '0;
    wait_idle("arb_idle_timeout");

    // Request dropped while waiting for a slot.
    trig_req = 4'b0011;
    repeat (3) step();
    check("drop_busy", 32'(sfx_en), 32'(4'b0011));
    trig_req[3] = 1'b1;
    ever = 1'b0;
    step(); ever |= sfx_en[3];
    step(); ever |= sfx_en[3];
    check("drop_pend_early", 32'(sfx_pending[3]), 32'd0);
    step(); ever |= sfx_en[3];
    check("drop_pend_rise", 32'(sfx_pending[3]), 32'd1);
    step(); ever |= sfx_en[3];
    step(); ever |= sfx_en[3];
    trig_req[3] = 1'b0;
    step(); ever |= sfx_en[3];
    step(); ever |= sfx_en[3];
    check("drop_pend_hold", 32'(sfx_pending[3]), 32'd1);
    step(); ever |= sfx_en[3];
    check("drop_pend_fall", 32'(sfx_pending[3]), 32'd0);
    check("drop_never_en", 32'(ever), 32'd0);
    trig_req = '0;
    wait_idle("drop_idle_timeout");

    // Retrigger during the release tail keeps the slot and reloads the hold.
    trig_req[0] = 1'b1;
    step();
    trig_req[0] = 1'b0;
    repeat (2) step();
    check("retrig_first_en", 32'(sfx_en[0]), 32'd1);
    guard = 0;
    while (sfx_en[0] && guard < 1000) begin
      step();
      guard++;
    end
    check("retrig_in_release", 32'(active_count), 32'd1);
    trig_req[0] = 1'b1;
    step();
    trig_req[0] = 1'b0;
    step();
    check("retrig_before", 32'(sfx_en[0]), 32'd0);
    step();
    check("retrig_active", 32'(sfx_en[0]), 32'd1);
    check("retrig_count", 32'(active_count), 32'd1);
    ticks = 0; guard = 0;
    while (sfx_en[0] && guard < 1000) begin
      ticks += int'(audio_clk_en);
      step();
      guard++;
    end
    check("retrig_hold_ticks", 32'(ticks), 32'(HOLD));
    wait_idle("retrig_idle_timeout");

    // High-priority request arriving while low-priority channels hold both slots.
    trig_req = 4'b1100;
    repeat (3) step();
    check("pre_setup", 32'(sfx_en), 32'(4'b1100));
    trig_req = 4'b1101;
    repeat (2) step();
    check("pre_before", 32'(sfx_en), 32'(4'b1100));
    step();
`ifdef SFX_PREEMPT_EN
    check("pre_swap", 32'(sfx_en), 32'(4'b0101));
    check("pre_swap_pending", 32'(sfx_pending), 32'd0);
    repeat (20) step();
    check("pre_no_replay", 32'(sfx_en[3]), 32'd0);
    check("pre_no_replay_pend", 32'(sfx_pending[3]), 32'd0);
`else
    check("nopre_hold", 32'(sfx_en), 32'(4'b1100));
    check("nopre_pending", 32'(sfx_pending), 32'(4'b0001));
    repeat (20) step();
    check("nopre_still_pending", 32'(sfx_pending), 32'(4'b0001));
`endif
    trig_req = '0;
    wait_idle("pre_idle_timeout");

    // Random request traffic with occasional short pulses.
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < NS; b++)
        if ($urandom_range(0, 23) == 0) trig_req[b] = ~trig_req[b];
      step();
    end

    // Asynchronous reset in the middle of play.
    trig_req = 4'b0111;
    repeat (6) step();
    #2;
    I_RSTn = 1'b0;
    #1;
    check("midrst_tick", 32'(audio_clk_en), 32'd0);
    check("midrst_sfx_en", 32'(sfx_en), 32'd0);
    check("midrst_pending", 32'(sfx_pending), 32'd0);
    check("midrst_active_count", 32'(active_count), 32'd0);
    trig_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    I_RSTn = 1'b1;
    repeat (50) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/discrete_sfx_sequencer.md
Name: discrete_sfx_sequencer

Overview:
Control block for the discrete sound circuits, such as the walk circuit.
- Generates the shared audio_clk_en sample tick from clk using an exact fractional accumulator.
- Turns game sound-latch request lines into per-effect enables (walk_en and siblings), with a minimum play time and a release tail.
- Caps the number of simultaneously active discrete circuits by fixed-priority arbitration.
- Sits between the CPU sound latch and the discrete circuit instances; its enables gate the circuits.

Parameters:
- CLOCK_RATE, 1000000: clk frequency in Hz.
- SAMPLE_RATE, 48000: audio tick rate in Hz; must be less than CLOCK_RATE.
- NUM_SFX, 4: number of effect channels; index 0 has the highest priority.
- MAX_ACTIVE, 2: maximum channels in ACTIVE or RELEASE at once; 1..NUM_SFX.
- MIN_HOLD_SAMPLES, 2400: minimum enable duration, in audio ticks.
- TAIL_SAMPLES, 4800: ticks a slot stays occupied after the enable drops, so circuit filters can decay.

Ports:
- clk, input, 1: system clock.
- I_RSTn, input, 1: reset, asynchronous, active-low.
- trig_req, input, NUM_SFX: level requests from the sound latch; asynchronous to the sound logic.
- audio_clk_en, output, 1: one-clk sample tick shared with the discrete circuits.
- sfx_en, output, NUM_SFX: per-channel circuit enable, registered.
- sfx_pending, output, NUM_SFX: channel requested but waiting for a free slot.
- active_count, output, $clog2(MAX_ACTIVE+1): number of occupied slots.

Behaviour:
- Reset (asynchronous, any time, including mid-play):
  - acc=0; all channels IDLE; all counters 0; synchronizers 0.
  - audio_clk_en, sfx_en, sfx_pending and active_count all 0.
- Tick generator, 32-bit acc, evaluated every clk edge:
  - nxt = acc + SAMPLE_RATE.
  - If nxt >= CLOCK_RATE: acc <= nxt - CLOCK_RATE and audio_clk_en <= 1.
  - Otherwise: acc <= nxt and audio_clk_en <= 0.
  - With defaults, the first tick is high after edge 21. The long-run rate is exact.
- Request input path:
  - trig_req passes through a 2-flop synchronizer; rise = sync & ~sync_d.
  - From trig_req rising to sfx_en high is 3 clk edges when a slot is free.
- Per-channel FSM (states IDLE, PENDING, ACTIVE, RELEASE):
  - IDLE, on rise: go to ACTIVE if granted, else PENDING.
  - PENDING: go to ACTIVE when granted. If the synced request drops first, go to IDLE (request dropped, never played).
  - ACTIVE:
    - sfx_en=1. hold is loaded with MIN_HOLD_SAMPLES on entry and on every rise (retrigger).
    - hold decrements on audio_clk_en and saturates at 0.
    - Go to RELEASE when hold==0 and sync==0. A request held high keeps the channel ACTIVE.
  - RELEASE:
    - sfx_en=0. tail is loaded with TAIL_SAMPLES and decrements on audio_clk_en.
    - Go to IDLE when tail==0. With TAIL_SAMPLES=0, RELEASE lasts exactly one clk.
    - A rise here goes directly to ACTIVE and keeps the slot, with no arbitration.
- Slots and arbitration:
  - A slot is occupied while the channel is in ACTIVE or RELEASE.
  - free = MAX_ACTIVE - occupied, evaluated from registered state each clk.
  - Grants go to requesting channels (IDLE with rise, or PENDING) in ascending index order, up to free; several grants are allowed in one cycle.
  - A slot freed at edge N can be granted at edge N+1, not in the same cycle.
- sfx_pending = (state==PENDING). active_count is registered and matches the occupied count.
- Counter width is $clog2(max(MIN_HOLD_SAMPLES, TAIL_SAMPLES)+1).

Optional Feature:
- Macro: SFX_PREEMPT_EN.
- Defined:
  - A PENDING or rising channel i with no free slot evicts the highest-index occupied channel j > i.
  - j is forced to IDLE, with sfx_en[j] low on the same edge that i enters ACTIVE.
  - j's request is dropped, even if still high; it only replays on a new rise.
  - At most one eviction per clk.
- Undefined: no preemption; requests wait in PENDING.

Decomposition:
- Package discrete_sfx_pkg holds:
  - typedef enum logic[1:0] sfx_state_t {IDLE, PENDING, ACTIVE, RELEASE};
  - the counter-width and accumulator-width localparams and function.
- Sub-module sample_tick_gen #(CLOCK_RATE, SAMPLE_RATE) holds the accumulator tick generator.

Test Plan (bench parameters NUM_SFX=4, MAX_ACTIVE=2, MIN_HOLD_SAMPLES=4, TAIL_SAMPLES=2, rates default unless stated):
- Tick: release reset and run 1,000,000 clk. Expect exactly 48000 ticks, the first after edge 21, and no two ticks in consecutive cycles.
- Minimum hold: trig_req[1] high for 1 clk. Expect sfx_en[1] high 3 edges later and staying high for 4 ticks. Expect active_count=1 until 2 further ticks after sfx_en falls, then 0.
- Arbitration: raise trig_req[3:0]=4'b1111 in the same cycle. Expect sfx_en=4'b0011 and sfx_pending=4'b1100. When channel 0 reaches IDLE, channel 2 is granted one edge later.
- Drop while pending: with two slots busy, pulse trig_req[3] for 5 clk. Expect sfx_pending[3] to rise, then fall 2 edges after the pulse ends; sfx_en[3] never rises.
- Retrigger: during RELEASE of channel 0, rise trig_req[0]. Expect ACTIVE again on the next edge, hold reloaded to 4, and active_count unchanged.
- With SFX_PREEMPT_EN defined: channels 2 and 3 active, then rise trig_req[0]. Expect sfx_en[3] to fall on the same edge sfx_en[0] rises; channel 3 stays IDLE although its request is still high. Reset asserted mid-play: all outputs 0 immediately.
